// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers, shared types and FSM encoding for the AES MixColumns engine.
// All constant multipliers are built from xtime chains; no lookup tables.
package aes_gf_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // The inverse coefficients all decompose into x8/x4/x2/x1 terms of one chain.
  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_mixcol_engine_if.sv
// Block handshake between a state producer/consumer (master) and the engine (slave).
// in_bypass exists only when AES_MIXCOL_BYPASS_EN is defined.
interface aes_mixcol_engine_if;
  import aes_gf_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   in_inv;
`ifdef AES_MIXCOL_BYPASS_EN
  logic   in_bypass;
`endif
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport master (
`ifdef AES_MIXCOL_BYPASS_EN
    output in_bypass,
`endif
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
`ifdef AES_MIXCOL_BYPASS_EN
    input  in_bypass,
`endif
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/aes_mixcol_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in the MSB byte).
module aes_mixcol_column
  import aes_gf_pkg::*;
(
  input  col_t col_i,
  input  logic inv_i,
  output col_t col_o
);

  logic [7:0] a [4];

  // NOTE: every variable written in always_comb gets a value on every path first, or a latch is inferred.
  always_comb begin
    for (int r = 0; r < 4; r++) a[r] = col_i[31-8*r -: 8];
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      if (inv_i) begin
        col_o[31-8*r -: 8] = gf_mul14(a[2'(r)])   ^ gf_mul11(a[2'(r+1)]) ^
                             gf_mul13(a[2'(r+2)]) ^ gf_mul9(a[2'(r+3)]);
      end else begin
        col_o[31-8*r -: 8] = gf_mul2(a[2'(r)]) ^ gf_mul3(a[2'(r+1)]) ^
                             a[2'(r+2)]        ^ a[2'(r+3)];
      end
    end
  end

endmodule

// File: rtl/aes_mixcol_engine.sv
// Handshaked AES MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per cycle.
// Optional feature macro: AES_MIXCOL_BYPASS_EN (adds in_bypass, copies columns unmixed).
module aes_mixcol_engine
  import aes_gf_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input logic               clk,
  input logic               rst,
  aes_mixcol_engine_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  mc_state_e  state_q,   state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  state_t     work_q,    work_d;
  logic       inv_q,     inv_d;
  logic       bypass_sel;

`ifdef AES_MIXCOL_BYPASS_EN
  logic bypass_q, bypass_d;
  assign bypass_sel = bypass_q;
`else
  assign bypass_sel = 1'b0;
`endif

  logic [1:0] col_idx [COLS_PER_CYCLE];
  col_t       col_in  [COLS_PER_CYCLE];
  col_t       col_out [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = col_cnt_q + 2'(k);
    assign col_in[k]  = work_q[127-32*int'(col_idx[k]) -: 32];

    aes_mixcol_column u_col (
      .col_i (col_in[k]),
      .inv_i (inv_q),
      .col_o (col_out[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
`ifdef AES_MIXCOL_BYPASS_EN
    bypass_d  = bypass_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          work_d    = bus.in_state;
          inv_d     = bus.in_inv;
`ifdef AES_MIXCOL_BYPASS_EN
          bypass_d  = bus.in_bypass;
`endif
          col_cnt_d = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[127-32*int'(col_idx[k]) -: 32] = bypass_sel ? col_in[k] : col_out[k];
        end
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_idx[COLS_PER_CYCLE-1] == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
      // NOTE: the working register doubles as out_state, so it is reset to give a defined zero output.
      work_q    <= '0;
      inv_q     <= 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
      inv_q     <= inv_d;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass_q  <= bypass_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_state = work_q;

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Self-checking bench: three engines (COLS_PER_CYCLE 4, 2, 1), directed vectors,
// backpressure, mid-block reset and a randomised forward/inverse round-trip run.
module tb_aes_mixcol_engine;
  import aes_gf_pkg::*;

  localparam int NL = 3;

  logic   clk = 1'b0;
  logic   rst;
  logic   tb_in_valid  [NL];
  state_t tb_in_state  [NL];
  logic   tb_in_inv    [NL];
  logic   tb_out_ready [NL];
  logic   tb_in_ready  [NL];
  logic   tb_out_valid [NL];
  state_t tb_out_state [NL];
`ifdef AES_MIXCOL_BYPASS_EN
  logic   tb_in_bypass [NL];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int CPC = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    aes_mixcol_engine_if bus ();
    assign bus.in_valid  = tb_in_valid[g];
    assign bus.in_state  = tb_in_state[g];
    assign bus.in_inv    = tb_in_inv[g];
    assign bus.out_ready = tb_out_ready[g];
`ifdef AES_MIXCOL_BYPASS_EN
    assign bus.in_bypass = tb_in_bypass[g];
`endif
    assign tb_in_ready[g]  = bus.in_ready;
    assign tb_out_valid[g] = bus.out_valid;
    assign tb_out_state[g] = bus.out_state;

    aes_mixcol_engine #(.COLS_PER_CYCLE(CPC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: shift-and-add multiply and a direct coefficient-matrix column mix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic state_t mix_ref(input state_t s, input logic inv);
    logic [7:0] c [4];
    logic [7:0] a [4];
    logic [7:0] o;
    state_t     r = '0;
    if (inv) begin c[0] = 8'd14; c[1] = 8'd11; c[2] = 8'd13; c[3] = 8'd9; end
    else     begin c[0] = 8'd2;  c[1] = 8'd3;  c[2] = 8'd1;  c[3] = 8'd1; end
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) a[row] = s[127-32*col-8*row -: 8];
      for (int row = 0; row < 4; row++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o ^= gmul(c[j], a[(row+j)%4]);
        r[127-32*col-8*row -: 8] = o;
      end
    end
    return r;
  endfunction

  localparam int LAT [NL] = '{1, 2, 4};

  // Offer a block, scramble inputs after accept, measure latency, then complete the output handshake.
  task automatic run_block(input int ln, input state_t st, input logic inv, input logic byp,
                           input int pre_idle, input int ready_delay,
                           output state_t res, output int lat);
    int guard = 0;
    repeat (pre_idle) @(negedge clk);
    tb_in_valid[ln] = 1'b1;
    tb_in_state[ln] = st;
    tb_in_inv[ln]   = inv;
`ifdef AES_MIXCOL_BYPASS_EN
    tb_in_bypass[ln] = byp;
`else
    if (byp) $display("bypass requested without AES_MIXCOL_BYPASS_EN");
`endif
    while (!tb_in_ready[ln] && guard < 50) begin @(negedge clk); guard++; end
    check("accept_in_time", 128'(guard < 50), 128'(1));
    @(negedge clk);
    tb_in_valid[ln] = 1'b0;
    tb_in_state[ln] = ~st;
    tb_in_inv[ln]   = ~inv;
`ifdef AES_MIXCOL_BYPASS_EN
    tb_in_bypass[ln] = ~byp;
`endif
    lat = 0;
    while (!tb_out_valid[ln] && lat < 50) begin @(negedge clk); lat++; end
    res = tb_out_state[ln];
    repeat (ready_delay) @(negedge clk);
    tb_out_ready[ln] = 1'b1;
    @(negedge clk);
    tb_out_ready[ln] = 1'b0;
  endtask

  typedef struct {
    int     lane;
    logic   inv;
    state_t din;
    state_t exp;
  } vec_t;

  localparam state_t FWD_IN  = {32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'hd4d4d4d5};
  localparam state_t FWD_OUT = {32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'hd5d5d7d6};
  localparam state_t INV_IN  = {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'h01010101};
  localparam state_t INV_OUT = {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'h01010101};

  initial begin
    vec_t   vecs [5];
    state_t res, res2, hold, blk_b, src;
    int     lat;
    logic   inv;

    vecs[0] = '{lane: 0, inv: 1'b0, din: FWD_IN, exp: FWD_OUT};
    vecs[1] = '{lane: 2, inv: 1'b1, din: INV_IN, exp: INV_OUT};
    vecs[2] = '{lane: 1, inv: 1'b0, din: FWD_IN, exp: FWD_OUT};
    vecs[3] = '{lane: 0, inv: 1'b1, din: INV_IN, exp: INV_OUT};
    vecs[4] = '{lane: 1, inv: 1'b1, din: FWD_OUT, exp: FWD_IN};

    for (int i = 0; i < NL; i++) begin
      tb_in_valid[i]  = 1'b0;
      tb_in_state[i]  = '0;
      tb_in_inv[i]    = 1'b0;
      tb_out_ready[i] = 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
      tb_in_bypass[i] = 1'b0;
`endif
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NL; i++) begin
      check($sformatf("reset_in_ready_l%0d", i),  128'(tb_in_ready[i]),  128'(1));
      check($sformatf("reset_out_valid_l%0d", i), 128'(tb_out_valid[i]), 128'(0));
      check($sformatf("reset_out_state_l%0d", i), tb_out_state[i],       '0);
    end

    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].lane, vecs[i].din, vecs[i].inv, 1'b0, 0, 0, res, lat);
      check($sformatf("vec%0d_state", i),   res,       vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(LAT[vecs[i].lane]));
    end

    // Backpressure on the 4-column engine with a second block offered during DONE.
    blk_b = {32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    tb_in_valid[0] = 1'b1; tb_in_state[0] = FWD_IN; tb_in_inv[0] = 1'b0;
    @(negedge clk);
    tb_in_state[0] = blk_b;
    @(negedge clk);
    check("bp_out_valid", 128'(tb_out_valid[0]), 128'(1));
    hold = tb_out_state[0];
    check("bp_result", hold, FWD_OUT);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_stable_c%0d", c),   tb_out_state[0],       FWD_OUT);
      check($sformatf("bp_in_ready_c%0d", c), 128'(tb_in_ready[0]),  128'(0));
      check($sformatf("bp_valid_c%0d", c),    128'(tb_out_valid[0]), 128'(1));
    end
    tb_out_ready[0] = 1'b1;
    @(negedge clk);
    tb_out_ready[0] = 1'b0;
    check("bp_idle_in_ready",  128'(tb_in_ready[0]),  128'(1));
    check("bp_idle_out_valid", 128'(tb_out_valid[0]), 128'(0));
    @(negedge clk);
    check("bp_second_accepted", 128'(tb_in_ready[0]), 128'(0));
    tb_in_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_second_valid",  128'(tb_out_valid[0]), 128'(1));
    check("bp_second_result", tb_out_state[0],       mix_ref(blk_b, 1'b0));
    tb_out_ready[0] = 1'b1;
    @(negedge clk);
    tb_out_ready[0] = 1'b0;

    // Reset during the second BUSY cycle of the 1-column engine.
    tb_in_valid[2] = 1'b1; tb_in_state[2] = FWD_IN; tb_in_inv[2] = 1'b0;
    @(negedge clk);
    tb_in_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy_out_valid", 128'(tb_out_valid[2]), 128'(0));
    check("rst_busy_out_state", tb_out_state[2],       '0);
    check("rst_busy_in_ready",  128'(tb_in_ready[2]),  128'(1));
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (tb_out_valid[2]) seen++;
      end
      check("rst_busy_no_result", 128'(seen), 128'(0));
    end

`ifdef AES_MIXCOL_BYPASS_EN
    src = {32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    run_block(0, src, 1'b0, 1'b1, 0, 0, res, lat);
    check("bypass_l0_state",   res,       src);
    check("bypass_l0_latency", 128'(lat), 128'(1));
    run_block(2, src, 1'b1, 1'b1, 0, 0, res, lat);
    check("bypass_l2_state",   res,       src);
    check("bypass_l2_latency", 128'(lat), 128'(4));
`endif

    // Random round trips: mix in a random direction, then undo it with the opposite direction.
    for (int ln = 0; ln < NL; ln++) begin
      for (int b = 0; b < 167; b++) begin
        src = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        run_block(ln, src, inv, 1'b0, $urandom_range(0, 2), $urandom_range(0, 3), res, lat);
        check($sformatf("rand_l%0d_b%0d_mix", ln, b),  res,       mix_ref(src, inv));
        check($sformatf("rand_l%0d_b%0d_lat", ln, b),  128'(lat), 128'(LAT[ln]));
        run_block(ln, res, ~inv, 1'b0, $urandom_range(0, 2), $urandom_range(0, 3), res2, lat);
        check($sformatf("rand_l%0d_b%0d_back", ln, b), res2,      src);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
